m_pcpi_frontend: RTL and testbench

PCPI-side front end of the M-extension co-processor. Sits between the core's PCPI bus and the M-unit controller/datapath. Decodes and captures one RV32M instruction and its operands, then issues a single start pulse to the unit and holds func3/rs1/rs2 stable until the unit completes. It also registers and returns the result, and adds a one-entry result cache and a completion watchdog.

---
 rtl/m_pcpi_frontend.sv | 150 +++++++++++++++
 tb/tb_m_pcpi_frontend.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/m_pcpi_frontend.sv
// PCPI front end for the RV32M unit: decode, operand capture, start/wait
// handshake, one-entry result cache and completion watchdog.
module m_pcpi_frontend #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit CACHE_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_start,
  output logic        m_abort,
  output logic [2:0]  m_func3,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_ready,
  input  logic [31:0] m_result,
  input  logic        cache_flush,
  output logic        err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  func3_q;
  logic [31:0] rs1_q, rs2_q, result_q;
  logic [7:0]  cnt_q;
  logic        c_valid_q;
  logic [2:0]  c_func3_q;
  logic [31:0] c_rs1_q, c_rs2_q, c_result_q;
  logic        err_q, wait_q;

  logic decode_hit, cache_hit, expire, done;
  logic unused_insn;

  assign unused_insn = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign decode_hit = pcpi_valid
                   && pcpi_insn[6:0]   == 7'b0110011
                   && pcpi_insn[31:25] == 7'b0000001;

  // A flush arriving with the instruction suppresses the lookup.
  assign cache_hit = CACHE_EN && c_valid_q && !cache_flush
                  && c_func3_q == pcpi_insn[14:12]
                  && c_rs1_q == pcpi_rs1
                  && c_rs2_q == pcpi_rs2;

  assign done   = state_q == S_WAIT && m_ready;
  assign expire = state_q == S_WAIT && !m_ready && cnt_q == TO_LAST;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (decode_hit) state_d = cache_hit ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:
        if (done)        state_d = S_RESP;
        else if (expire) state_d = S_GAP;
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcpi_wr    = 1'b0;
    pcpi_ready = 1'b0;
    pcpi_rd    = '0;
    m_start    = 1'b0;
    m_abort    = expire;
    m_func3    = '0;
    m_rs1      = '0;
    m_rs2      = '0;
    unique case (state_q)
      S_ISSUE, S_WAIT: begin
        m_start = state_q == S_ISSUE;
        m_func3 = func3_q;
        m_rs1   = rs1_q;
        m_rs2   = rs2_q;
      end
      S_RESP: begin
        pcpi_wr    = 1'b1;
        pcpi_ready = 1'b1;
        pcpi_rd    = result_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      func3_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      c_valid_q  <= 1'b0;
      c_func3_q  <= '0;
      c_rs1_q    <= '0;
      c_rs2_q    <= '0;
      c_result_q <= '0;
      err_q      <= 1'b0;
      wait_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && decode_hit) begin
        func3_q <= pcpi_insn[14:12];
        rs1_q   <= pcpi_rs1;
        rs2_q   <= pcpi_rs2;
        if (cache_hit) result_q <= c_result_q;
      end
      if (state_q == S_ISSUE)     cnt_q <= '0;
      else if (state_q == S_WAIT) cnt_q <= cnt_q + 8'd1;
      if (done) begin
        result_q <= m_result;
        if (CACHE_EN) begin
          c_valid_q  <= 1'b1;
          c_func3_q  <= func3_q;
          c_rs1_q    <= rs1_q;
          c_rs2_q    <= rs2_q;
          c_result_q <= m_result;
        end
      end
      if (cache_flush) c_valid_q <= 1'b0;
      if (expire)      err_q     <= 1'b1;
      wait_q <= state_d == S_ISSUE
             || state_d == S_WAIT
             || state_d == S_RESP;
    end
  end

  assign pcpi_wait   = wait_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// Directed plus randomized bench for m_pcpi_frontend against a
// transaction-level cache/latency model.
module tb_m_pcpi_frontend;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0] pcpi_rd;
  logic        m_start, m_abort, m_ready;
  logic [2:0]  m_func3;
  logic [31:0] m_rs1, m_rs2, m_result;
  logic        cache_flush, err_timeout;

  m_pcpi_frontend #(.TIMEOUT_CYCLES(T), .CACHE_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .m_start(m_start), .m_abort(m_abort),
    .m_func3(m_func3), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_ready(m_ready), .m_result(m_result),
    .cache_flush(cache_flush), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] MUL  = 32'h022081B3;
  localparam logic [31:0] DIV  = 32'h0220C1B3;
  localparam logic [31:0] REM  = 32'h0220E1B3;
  localparam logic [31:0] MULH = 32'h022091B3;
  localparam logic [31:0] ADD  = 32'h002081B3;

  int checks = 0;
  int failures = 0;

  // Reference model: the single cached entry and the sticky error.
  bit          mv;
  logic [2:0]  mf;
  logic [31:0] m1, m2, mr;
  bit          err_m;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_out();
    return {pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready, m_start,
            m_abort, m_func3, m_rs1, m_rs2, err_timeout};
  endfunction

  // lat: m_ready is raised in WAIT cycle lat-1 (lat cycles after m_start).
  task automatic do_txn(input logic [31:0] insn, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] res, input bit flush);
    logic [2:0] f;
    bit hit, fin, tmo;
    f = insn[14:12];
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = insn;
    pcpi_rs1 = a; pcpi_rs2 = b; cache_flush = flush;
    hit = !flush && mv && mf == f && m1 == a && m2 == b;
    if (flush) mv = 1'b0;
    @(negedge clk);
    cache_flush = 1'b0;
    tmo = 1'b0;
    if (hit) begin
      chk("hit_ready", {pcpi_ready, pcpi_wr}, 2'b11);
      chk("hit_rd", pcpi_rd, mr);
      chk("hit_nostart", m_start, 1'b0);
      chk("hit_wait", pcpi_wait, 1'b1);
    end else begin
      chk("iss_start", m_start, 1'b1);
      chk("iss_wait", pcpi_wait, 1'b1);
      chk("iss_ready", pcpi_ready, 1'b0);
      chk("iss_ops", {m_func3, m_rs1, m_rs2}, {f, a, b});
      fin = 1'b0;
      for (int c = 0; c < 300 && !fin; c++) begin
        @(negedge clk);
        m_ready  = (c == lat - 1);
        m_result = m_ready ? res : $urandom;
        #1;
        chk("wt_state", {pcpi_wait, pcpi_ready, m_start}, 3'b100);
        chk("wt_ops", {m_func3, m_rs1, m_rs2}, {f, a, b});
        chk("wt_abort", m_abort, !m_ready && c == T - 1);
        if (m_ready) fin = 1'b1;
        else if (c == T - 1) begin
          fin = 1'b1; tmo = 1'b1; err_m = 1'b1;
        end
      end
      if (!fin) chk("wait_bound", 1'b0, 1'b1);
      @(negedge clk);
      m_ready = 1'b0;
      if (!tmo) begin
        chk("rsp_ready", {pcpi_ready, pcpi_wr}, 2'b11);
        chk("rsp_rd", pcpi_rd, res);
        chk("rsp_wait", pcpi_wait, 1'b1);
        mv = 1'b1; mf = f; m1 = a; m2 = b; mr = res;
      end
    end
    if (!hit && !tmo) @(negedge clk);
    if (hit) @(negedge clk);
    // GAP: valid still held and a stray m_ready must be ignored.
    chk("gap", {pcpi_wait, pcpi_ready, pcpi_wr, m_start, m_abort},
        5'b0);
    m_ready = 1'b1; m_result = $urandom;
    @(negedge clk);
    m_ready = 1'b0;
    chk("idle_wait", {pcpi_wait, m_start}, 2'b00);
    chk("err", err_timeout, err_m);
    pcpi_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0;
    pcpi_rs1 = '0; pcpi_rs2 = '0; m_ready = 1'b0;
    m_result = '0; cache_flush = 1'b0;
    mv = 1'b0; mf = '0; m1 = '0; m2 = '0; mr = '0; err_m = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", all_out(), '0);
    reset = 1'b0;

    do_txn(MUL, 32'd7, 32'd6, 3, 32'd42, 1'b0);
    do_txn(MUL, 32'd7, 32'd6, 3, 32'd42, 1'b0);
    do_txn(MUL, 32'd7, 32'd6, 3, 32'd42, 1'b1);
    do_txn(DIV, 32'd100, 32'd7, 2, 32'd14, 1'b0);
    do_txn(REM, 32'd100, 32'd7, 2, 32'd2, 1'b0);

    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = ADD;
    pcpi_rs1 = 32'd7; pcpi_rs2 = 32'd6;
    repeat (20) begin
      @(negedge clk);
      chk("nonm", {pcpi_wait, pcpi_ready, m_start}, 3'b000);
    end
    pcpi_valid = 1'b0;

    do_txn(MULH, 32'd11, 32'd13, 1000, 32'd143, 1'b0);
    do_txn(MULH, 32'd11, 32'd13, T, 32'd143, 1'b0);
    do_txn(MUL, 32'd7, 32'd6, 1, 32'd42, 1'b0);

    // Reset two cycles into WAIT of an unrelated miss.
    @(negedge clk);
    pcpi_valid = 1'b1; pcpi_insn = MUL;
    pcpi_rs1 = 32'd5; pcpi_rs2 = 32'd5;
    @(negedge clk);
    chk("rst_iss", m_start, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1; pcpi_valid = 1'b0;
    @(negedge clk);
    chk("rst_outs", all_out(), '0);
    reset = 1'b0;
    mv = 1'b0; err_m = 1'b0;
    do_txn(MUL, 32'd7, 32'd6, 2, 32'd42, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 2));
      b  = (i % 3 == 0) ? $urandom : 32'd9;
      do_txn({7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011}, a, b,
             $urandom_range(1, T + 1), $urandom,
             $urandom_range(0, 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
